// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int DELAY_FRAMES   = 234;
    localparam int GAP_CYCLES_DEF = DELAY_FRAMES;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_GAP
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side byte streams of the UART arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    byte_t                tx_data;
    logic                 tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request above lastOwner, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] lastOwner,
    output logic [N-1:0]  winOneHot,
    output logic [IW-1:0] winIdx,
    output logic          anyReq
);

    always_comb begin : pick
        int cand;
        cand      = 0;
        winOneHot = '0;
        winIdx    = lastOwner;
        anyReq    = 1'b0;
        // lastOwner itself is visited last, so a lone requester still wins
        for (int k = 1; k <= N; k++) begin
            cand = (int'(lastOwner) + k) % N;
            if (!anyReq && req[cand]) begin
                anyReq          = 1'b1;
                winIdx          = IW'(cand);
                winOneHot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of a shared UART byte transmitter.
// Define UART_ARB_TIMEOUT_EN to revoke a grant whose owner stalls for TIMEOUT_CYCLES.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               timeout_abort
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_e         state, stateNext;
    logic [IW-1:0]      lastOwner, lastOwnerNext;
    logic [GW-1:0]      gapCnt, gapCntNext;
    logic [NUM_REQ-1:0] grantNext;
    logic [NUM_REQ-1:0] winOneHot;
    logic [IW-1:0]      winIdx;
    logic               anyReq;
    logic               ownerValid, ownerLast, xfer, stallTrip;

    rr_pick #(.N(NUM_REQ), .IW(IW)) picker (
        .req       (bus.req_valid),
        .lastOwner (lastOwner),
        .winOneHot (winOneHot),
        .winIdx    (winIdx),
        .anyReq    (anyReq)
    );

    // lastOwner doubles as the current owner while in SEND
    assign ownerValid = bus.req_valid[lastOwner];
    assign ownerLast  = bus.req_last[lastOwner];
    assign xfer       = (state == ARB_SEND) && ownerValid && bus.tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stallCnt;

    // Only owner-side silence counts; transmitter back-pressure never does
    always_ff @(posedge clk) begin
        if (!rst_n || state != ARB_SEND || xfer)
            stallCnt <= '0;
        else if (!ownerValid)
            stallCnt <= stallCnt + 1'b1;
    end

    assign stallTrip = (state == ARB_SEND) && !ownerValid &&
                       (stallCnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign stallTrip = 1'b0;
`endif

    assign timeout_abort = stallTrip;
    assign busy          = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            lastOwner <= IW'(NUM_REQ - 1);
            gapCnt    <= '0;
            grant     <= '0;
        end else begin
            state     <= stateNext;
            lastOwner <= lastOwnerNext;
            gapCnt    <= gapCntNext;
            grant     <= grantNext;
        end
    end

    always_comb begin
        stateNext     = state;
        lastOwnerNext = lastOwner;
        gapCntNext    = gapCnt;
        grantNext     = grant;
        case (state)
            ARB_IDLE: begin
                if (anyReq) begin
                    stateNext     = ARB_SEND;
                    lastOwnerNext = winIdx;
                    grantNext     = winOneHot;
                end
            end
            ARB_SEND: begin
                if ((xfer && ownerLast) || stallTrip) begin
                    stateNext  = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
                    gapCntNext = '0;
                    grantNext  = '0;
                end
            end
            ARB_GAP: begin
                if (gapCnt == GW'(GAP_CYCLES - 1)) begin
                    stateNext  = ARB_IDLE;
                    gapCntNext = '0;
                end else begin
                    gapCntNext = gapCnt + 1'b1;
                end
            end
            default: begin
                stateNext = ARB_IDLE;
                grantNext = '0;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        if (state == ARB_SEND) begin
            bus.req_ready[lastOwner] = bus.tx_ready;
            bus.tx_valid             = ownerValid;
            bus.tx_data              = bus.req_data[{lastOwner, 3'b000} +: 8];
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-level UART transmitter between NUM_REQ requesters, such as the button-triggered message sender, the RX echo path and debug dump logic.
- Each requester streams a message as a sequence of bytes over valid/ready. The last byte is flagged.
- A grant is held for a whole message, then passed on round-robin.
- Sits between the requesters and the transmitter's byte input. An idle gap after each message gives the receiver line-idle time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 234, idle clocks after each message's last byte (one bit time at 27 MHz / 115200). 0 means no gap.
- TIMEOUT_CYCLES, 2700000, stall limit while granted (100 ms at 27 MHz). Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of its message
- req_ready  out  NUM_REQ  byte accepted from requester i
- tx_valid  out  1  byte offered to the transmitter
- tx_data  out  8  byte to the transmitter
- tx_ready  in  1  transmitter can accept a byte
- grant  out  NUM_REQ  one-hot current owner; all zeros when not granted
- busy  out  1  high in any state other than IDLE
- timeout_abort  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- States: IDLE, SEND, GAP.
- Reset (rst_n=0 sampled at a clk edge):
  - state=IDLE, grant=0, busy=0, tx_valid=0, req_ready=0, timeout_abort=0, counters=0.
  - Round-robin pointer is set so requester 0 wins first (last_owner = NUM_REQ-1).
  - Reset mid-message drops the grant at that edge. The partially sent message is not resumed.
- IDLE:
  - If any req_valid is high, select the first requester with req_valid high, searching upward from last_owner+1 with wrap-around.
  - Next edge: grant becomes one-hot for the winner, last_owner is updated, state=SEND.
  - Grant latency is one cycle. No byte transfers in IDLE.
- SEND (owner g):
  - tx_valid = req_valid[g], tx_data = req_data[g]; both combinational.
  - req_ready[g] = tx_ready. All other req_ready bits are 0.
  - A transfer occurs when tx_valid and tx_ready are both high.
  - Transfer with req_last[g]=1: next state is GAP, or IDLE if GAP_CYCLES=0. grant clears at the same edge.
  - Non-granted requesters may hold req_valid high indefinitely. They are never acknowledged.
- GAP:
  - tx_valid=0, grant=0, busy=1.
  - Count GAP_CYCLES clocks, then go to IDLE.
  - Arbitration resumes from IDLE, so the shortest turnaround between messages is GAP_CYCLES+1 idle cycles.
- Fairness: a requester that keeps requesting is granted at most once per NUM_REQ consecutive grants while others are waiting.
- Simultaneous events:
  - A last-byte transfer and a new request on the same cycle: the new request is arbitrated only from IDLE.
  - A requester that drops req_valid mid-message keeps the grant (unless timeout is enabled).
- Width rules:
  - Gap counter is $clog2(GAP_CYCLES+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
  - Pointer is $clog2(NUM_REQ) bits and wraps modulo NUM_REQ.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - In SEND, a stall counter increments on each cycle with req_valid[g]=0. It clears on every transfer and on entry to SEND.
  - When the counter reaches TIMEOUT_CYCLES: timeout_abort pulses high for one cycle, grant clears, state=GAP.
  - Stalls caused by tx_ready=0 while req_valid[g]=1 never count.
- Not defined: no stall counter is built, timeout_abort is tied to 0, and a grant is held until the last-byte transfer or reset.

Decomposition:
- Package uart_pkg holds:
  - the state enum (ARB_IDLE, ARB_SEND, ARB_GAP);
  - the DELAY_FRAMES default (234) and the derived default for GAP_CYCLES;
  - a byte_t typedef (8-bit).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector and last_owner. Outputs: one-hot winner and its index.
  - Reusable by future shared-resource arbiters.

Test Plan:
- Reset, then requester 1 sends 3 bytes 0x4C, 0x75, 0x73 with last on 0x73 and tx_ready always 1. Expected:
  - grant=0b0010 one cycle after req_valid[1] rises;
  - tx_data sequence is 4C, 75, 73;
  - grant=0 after 0x73;
  - busy stays high for 234 more cycles.
- All 4 requesters request continuously with 1-byte messages and GAP_CYCLES=0 → grant order 0,1,2,3,0,1, each owner sends exactly one byte per turn.
- Requester 2 is mid-message, tx_ready is held 0 for 500 cycles and requester 0 is requesting → grant stays 0b0100, req_ready[0]=0, no bytes are lost or duplicated.
- rst_n is driven low during byte 2 of a 5-byte message → next cycle grant=0, tx_valid=0, busy=0. After release, requester 0 is granted first.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, owner 3 drops req_valid after byte 1 → timeout_abort pulses on the 100th stall cycle, grant clears, GAP is entered, then a pending requester 0 is granted.
- Without the macro, the same stimulus → grant=0b1000 held for 10000 cycles and timeout_abort stays 0.
